// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants, state type and winner search for the 6-way arbiter
package rr_mux_pkg;

   localparam int N_REQ = 6;
   localparam int SEL_W = 3;
   localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

   typedef enum logic {IDLE, GRANT} state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } win_t;

   // First set request bit, scanning upward from ptr and wrapping 5 -> 0.
   function automatic win_t next_winner(input logic [N_REQ-1:0] req,
                                        input logic [SEL_W-1:0] ptr);
      win_t w;
      int   j;
      w.found = 1'b0;
      w.idx   = SEL_IDLE;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!w.found && req[j]) begin
            w.found = 1'b1;
            w.idx   = SEL_W'(j);
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/mux6_4b.sv
// rtl/mux6_4b.sv - combinational 6:1 x 4-bit mux, zero output for unused selects
module mux6_4b (
   input  logic [2:0] sel,
   input  logic [3:0] data0,
   input  logic [3:0] data1,
   input  logic [3:0] data2,
   input  logic [3:0] data3,
   input  logic [3:0] data4,
   input  logic [3:0] data5,
   output logic [3:0] out
);

   // Select one payload; selects 6 and 7 give the idle value.
   always_comb begin
      out = 4'b0000;
      case (sel)
         3'd0:    out = data0;
         3'd1:    out = data1;
         3'd2:    out = data2;
         3'd3:    out = data3;
         3'd4:    out = data4;
         3'd5:    out = data5;
         default: out = 4'b0000;
      endcase
   end

endmodule

// File: rtl/rr_mux6_arbiter.sv
// rtl/rr_mux6_arbiter.sv - round-robin burst arbiter owning the select of a 6:1 x 4-bit mux
module rr_mux6_arbiter
   import rr_mux_pkg::*;
#(
   parameter int HOLD  = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [3:0]       data0,
   input  logic [3:0]       data1,
   input  logic [3:0]       data2,
   input  logic [3:0]       data3,
   input  logic [3:0]       data4,
   input  logic [3:0]       data5,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic [3:0]       out,
   output logic             valid
);

   state_t           state, state_n;
   logic [SEL_W-1:0] ptr, ptr_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [N_REQ-1:0] gnt_n;
   logic [SEL_W-1:0] sel_n;
   logic             valid_n;
   logic [SEL_W-1:0] ptr_rel;
   logic [SEL_W-1:0] arb_ptr;
   logic             release_now;
   win_t             win;

   // Register all arbiter state; reset drops any grant at the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= SEL_IDLE;
         valid <= 1'b0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         sel   <= sel_n;
         valid <= valid_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state: grant from idle, count the burst, or release and re-arbitrate in the same edge.
   always_comb begin
      state_n     = state;
      gnt_n       = gnt;
      sel_n       = sel;
      valid_n     = valid;
      ptr_n       = ptr;
      cnt_n       = cnt;
      ptr_rel     = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
      // While granted, arbitration only matters on release, where the rotated pointer applies.
      arb_ptr     = (state == GRANT) ? ptr_rel : ptr;
      win         = next_winner(req, arb_ptr);
      release_now = (!req[sel]) || (cnt == CNT_W'(HOLD));
      case (state)
         IDLE: begin
            if (win.found) begin
               state_n = GRANT;
               gnt_n   = N_REQ'(1) << win.idx;
               sel_n   = win.idx;
               cnt_n   = CNT_W'(1);
               valid_n = 1'b1;
            end
         end
         GRANT: begin
            if (!release_now) begin
               cnt_n = cnt + CNT_W'(1);
            end else begin
               ptr_n = ptr_rel;
               if (win.found) begin
                  gnt_n   = N_REQ'(1) << win.idx;
                  sel_n   = win.idx;
                  cnt_n   = CNT_W'(1);
                  valid_n = 1'b1;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  sel_n   = SEL_IDLE;
                  cnt_n   = '0;
                  valid_n = 1'b0;
               end
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            sel_n   = SEL_IDLE;
            valid_n = 1'b0;
         end
      endcase
   end

   mux6_4b u_mux (
      .sel   (sel),
      .data0 (data0),
      .data1 (data1),
      .data2 (data2),
      .data3 (data3),
      .data4 (data4),
      .data5 (data5),
      .out   (out)
   );

   a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
   a_valid_or:   assert property (@(posedge clk) disable iff (reset) valid == (|gnt));
   a_sel_match:  assert property (@(posedge clk) disable iff (reset)
                                  valid ? (gnt == (N_REQ'(1) << sel)) : (sel == SEL_IDLE));
   a_cnt_bound:  assert property (@(posedge clk) disable iff (reset) cnt <= CNT_W'(HOLD));
   a_ptr_range:  assert property (@(posedge clk) disable iff (reset) ptr < SEL_W'(N_REQ));

endmodule

// File: tb/tb_rr_mux6_arbiter.sv
// tb/tb_rr_mux6_arbiter.sv - directed self-checking bench for rr_mux6_arbiter
module tb_rr_mux6_arbiter;
   import rr_mux_pkg::*;

   logic       clk;
   logic       reset;
   logic [5:0] req;
   logic [3:0] d [6];
   logic [5:0] gnt;
   logic [2:0] sel;
   logic [3:0] out;
   logic       valid;

   int errors = 0;
   int checks = 0;

   rr_mux6_arbiter #(.HOLD(4), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .data0 (d[0]),
      .data1 (d[1]),
      .data2 (d[2]),
      .data3 (d[3]),
      .data4 (d[4]),
      .data5 (d[5]),
      .gnt   (gnt),
      .sel   (sel),
      .out   (out),
      .valid (valid)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      step();
      reset = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".gnt"},   32'(gnt),   32'h0);
      check({tag, ".sel"},   32'(sel),   32'h7);
      check({tag, ".valid"}, 32'(valid), 32'h0);
      check({tag, ".out"},   32'(out),   32'h0);
   endtask

   task automatic check_grant(input string tag, input int idx, input logic [3:0] exp_out);
      check({tag, ".gnt"},   32'(gnt),   32'(6'b1 << idx));
      check({tag, ".sel"},   32'(sel),   32'(idx));
      check({tag, ".valid"}, 32'(valid), 32'h1);
      check({tag, ".out"},   32'(out),   32'(exp_out));
   endtask

   initial begin
      logic [3:0] pat [6];
      pat[0] = 4'h9; pat[1] = 4'h3; pat[2] = 4'hC;
      pat[3] = 4'h5; pat[4] = 4'hE; pat[5] = 4'h7;
      for (int i = 0; i < 6; i++) d[i] = pat[i];
      reset = 1'b1;
      req   = '0;

      // 1. reset and idle, then reset in the middle of a grant
      step();
      step();
      check_idle("t1_rst");
      reset = 1'b0;
      step();
      check_idle("t1_idle");
      req = 6'b000010;
      step();
      check_grant("t1_g1", 1, pat[1]);
      req = 6'b000000;
      step();
      check_idle("t1_rel");
      check("t1_ptr_rel", 32'(dut.ptr), 32'd2);
      req = 6'b000010;
      step();
      check_grant("t1_g1b", 1, pat[1]);
      reset = 1'b1;
      step();
      check_idle("t1_midrst");
      check("t1_ptr0", 32'(dut.ptr), 32'd0);
      reset = 1'b0;
      req   = '0;

      // 2. single requester: burst counter wraps, grant never drops
      req = 6'b000100;
      for (int k = 1; k <= 10; k++) begin
         step();
         check_grant($sformatf("t2_c%0d", k), 2, pat[2]);
         check($sformatf("t2_cnt%0d", k), 32'(dut.cnt), 32'(((k - 1) % 4) + 1));
      end
      req = '0;
      step();
      check_idle("t2_end");

      // 3. full contention from ptr=0: 4-cycle bursts rotating 0..5, 0
      do_reset();
      req = 6'h3F;
      for (int k = 1; k <= 28; k++) begin
         step();
         check_grant($sformatf("t3_c%0d", k), ((k - 1) / 4) % 6, pat[((k - 1) / 4) % 6]);
         check($sformatf("t3_cnt%0d", k), 32'(dut.cnt), 32'(((k - 1) % 4) + 1));
      end

      // 4. early drop after two grant cycles
      do_reset();
      req = 6'b001000;
      step();
      check_grant("t4_e1", 3, pat[3]);
      step();
      check_grant("t4_e2", 3, pat[3]);
      req = '0;
      step();
      check_idle("t4_e3");
      check("t4_ptr", 32'(dut.ptr), 32'd4);
      check("t4_state", 32'(dut.state), 32'(IDLE));

      // 5. wrap-around: after 5 releases, index 0 beats index 4 with no bubble
      do_reset();
      req = 6'b100000;
      step();
      check_grant("t5_g5", 5, pat[5]);
      req = 6'b010001;
      step();
      check_grant("t5_g0", 0, pat[0]);
      check("t5_ptr", 32'(dut.ptr), 32'd0);

      // 6. data path is combinational on the registered select
      do_reset();
      d[4] = 4'hA;
      req  = 6'b010000;
      step();
      check_grant("t6_a", 4, 4'hA);
      d[4] = 4'h5;
      #1;
      check("t6_same_cycle", 32'(out), 32'h5);
      step();
      check("t6_hold", 32'(out), 32'h5);
      req = '0;
      step();
      check_idle("t6_idle");
      for (int i = 0; i < 6; i++) d[i] = 4'hF;
      #1;
      check("t6_idle_data", 32'(out), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
